// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU command sequencer: ALU opcode encodings,
// sequencer FSM states and the width of one buffered command record.
package alu_seq_pkg;

    localparam int unsigned OP_W = 4;

    // Opcode encodings, identical to the accumulating ALU.
    localparam logic [OP_W-1:0] OP_NOOP  = 4'b0000;
    localparam logic [OP_W-1:0] OP_ADD   = 4'b0001;
    localparam logic [OP_W-1:0] OP_SUB   = 4'b0010;
    localparam logic [OP_W-1:0] OP_MULT  = 4'b0011;
    localparam logic [OP_W-1:0] OP_DIV   = 4'b0100;
    localparam logic [OP_W-1:0] OP_AND   = 4'b0101;
    localparam logic [OP_W-1:0] OP_OR    = 4'b0110;
    localparam logic [OP_W-1:0] OP_XOR   = 4'b0111;
    localparam logic [OP_W-1:0] OP_NOT   = 4'b1000;
    localparam logic [OP_W-1:0] OP_RESET = 4'b1111;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_FIRST = 3'd2,
        ST_WARM  = 3'd3,
        ST_ISSUE = 3'd4,
        ST_HOLD  = 3'd5
    } state_t;

    // Command record {op, a, b, last}.
    function automatic int unsigned cmd_width(int unsigned w);
        return OP_W + 2 * w + 1;
    endfunction

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Command and result handshake bundle of the ALU command sequencer.
//   master : command source / result sink (testbench, decoder)
//   slave  : the sequencer
// res_err exists only when ALU_SEQ_ERR_EN is defined.
interface alu_cmd_sequencer_if #(
    parameter int unsigned W = 16
);
    logic         cmd_valid;
    logic         cmd_ready;
    logic [3:0]   cmd_op;
    logic [W-1:0] cmd_a;
    logic [W-1:0] cmd_b;
    logic         cmd_last;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] res_data;
    logic [7:0]   res_count;
`ifdef ALU_SEQ_ERR_EN
    logic         res_err;
`endif

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_last, res_ready,
        input  cmd_ready, res_valid, res_data, res_count
`ifdef ALU_SEQ_ERR_EN
        , input res_err
`endif
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_last, res_ready,
        output cmd_ready, res_valid, res_data, res_count
`ifdef ALU_SEQ_ERR_EN
        , output res_err
`endif
    );

endinterface

// File: rtl/alu_cmd_sequencer_fifo.sv
// alu_cmd_fifo: synchronous command FIFO with full/empty flags.
//   clk, clear_n : clock, synchronous active-low clear (empties the FIFO)
//   push, wdata  : write request / record; ignored when full
//   pop, rdata   : read request / head record; ignored when empty
//   full, empty  : occupancy flags
module alu_cmd_fifo
    import alu_seq_pkg::*;
#(
    parameter int unsigned W     = 16,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic                clk,
    input  logic                clear_n,
    input  logic                push,
    input  logic [OP_W+2*W:0]   wdata,
    input  logic                pop,
    output logic [OP_W+2*W:0]   rdata,
    output logic                full,
    output logic                empty
);

    logic [OP_W+2*W:0] mem [DEPTH];
    logic [AW-1:0]     wptr;
    logic [AW-1:0]     rptr;
    logic [AW:0]       cnt;
    logic              do_push;
    logic              do_pop;

    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rptr];

    // Pointers wrap naturally at DEPTH (power of two).
    always_ff @(posedge clk) begin
        if (!clear_n) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage needs no reset; occupancy is tracked by cnt.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: buffers ALU commands, groups them into chains, clears
// the ALU per chain, issues one op per cycle after the ALU warm-up and
// returns each chain's final accumulated result.
//   clk, clear_n          : clock, synchronous active-low reset
//   cmd_if (slave)        : cmd_valid/ready/op/a/b/last, res_valid/ready/data/count
//   alu_clear/opcode/input1/input2 : combinational drive to the ALU
//   alu_out, alu_has_last : ALU result (same cycle) and warm-up flag
// Optional: ALU_SEQ_ERR_EN adds cmd_if.res_err and squashes illegal ops
// (opcodes 1001-1110, DIV by zero) to NOOP.
module alu_cmd_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned W     = 16,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic                 clk,
    input  logic                 clear_n,
    alu_cmd_sequencer_if.slave   cmd_if,
    output logic                 alu_clear,
    output logic [3:0]           alu_opcode,
    output logic [W-1:0]         alu_input1,
    output logic [W-1:0]         alu_input2,
    input  logic [W-1:0]         alu_out,
    input  logic                 alu_has_last
);

    localparam int unsigned CW = cmd_width(W);

    state_t          state_q, state_d;
    logic [CW-1:0]   head;
    logic [CW-1:0]   wdata;
    logic            full, empty, pop, capture;
    logic [3:0]      head_op, fwd_op;
    logic [W-1:0]    head_a, head_b;
    logic            head_last;
    logic [W-1:0]    res_data_q;
    logic [7:0]      count_q;

    assign wdata     = {cmd_if.cmd_op, cmd_if.cmd_a, cmd_if.cmd_b, cmd_if.cmd_last};
    assign head_op   = head[CW-1 -: OP_W];
    assign head_a    = head[CW-OP_W-1 -: W];
    assign head_b    = head[W:1];
    assign head_last = head[0];

    alu_cmd_fifo #(.W(W), .DEPTH(DEPTH), .AW(AW)) u_fifo (
        .clk     (clk),
        .clear_n (clear_n),
        .push    (cmd_if.cmd_valid),
        .wdata   (wdata),
        .pop     (pop),
        .rdata   (head),
        .full    (full),
        .empty   (empty)
    );

`ifdef ALU_SEQ_ERR_EN
    logic head_bad;
    logic err_q;

    assign head_bad = ((head_op >= 4'b1001) && (head_op <= 4'b1110)) ||
                      ((head_op == OP_DIV) && (head_b == '0));
    assign fwd_op   = head_bad ? OP_NOOP : head_op;
    assign cmd_if.res_err = err_q;

    // Error flag accumulates over the chain; cleared as a new chain starts.
    always_ff @(posedge clk) begin
        if (!clear_n)                 err_q <= 1'b0;
        else if (state_q == ST_CLEAR) err_q <= 1'b0;
        else if (pop && head_bad)     err_q <= 1'b1;
    end
`else
    assign fwd_op = head_op;
`endif

    assign cmd_if.cmd_ready = ~full;
    assign cmd_if.res_valid = (state_q == ST_HOLD);
    assign cmd_if.res_data  = res_data_q;
    assign cmd_if.res_count = count_q;

    // Next state and ALU drive; ALU is held in clear while reset is asserted.
    always_comb begin
        state_d    = state_q;
        pop        = 1'b0;
        capture    = 1'b0;
        alu_clear  = ~clear_n;
        alu_opcode = OP_NOOP;
        alu_input1 = '0;
        alu_input2 = '0;
        case (state_q)
            ST_IDLE: begin
                if (!empty) state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
                alu_clear = 1'b1;
                state_d   = ST_FIRST;
            end
            ST_FIRST, ST_ISSUE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    alu_opcode = fwd_op;
                    alu_input1 = head_a;
                    alu_input2 = head_b;
                    if (head_last) begin
                        capture = 1'b1;
                        state_d = ST_HOLD;
                    end else if (state_q == ST_FIRST) begin
                        state_d = ST_WARM;
                    end
                end
            end
            ST_WARM: begin
                if (alu_has_last) state_d = ST_ISSUE;
            end
            ST_HOLD: begin
                if (cmd_if.res_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, result and saturating op count.
    always_ff @(posedge clk) begin
        if (!clear_n) begin
            state_q    <= ST_IDLE;
            res_data_q <= '0;
            count_q    <= '0;
        end else begin
            state_q <= state_d;
            if (pop) begin
                if (state_q == ST_FIRST)  count_q <= 8'd1;
                else if (count_q != 8'hFF) count_q <= count_q + 8'd1;
            end
            if (capture) res_data_q <= alu_out;
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed self-checking bench for alu_cmd_sequencer with a behavioural
// accumulating-ALU model. Honours ALU_SEQ_ERR_EN when defined.
module tb_alu_cmd_sequencer;
    import alu_seq_pkg::*;

    localparam int unsigned W = 16;

    logic         clk = 1'b0;
    logic         clear_n;
    logic         alu_clear;
    logic [3:0]   alu_opcode;
    logic [W-1:0] alu_input1, alu_input2, alu_out;
    logic         alu_has_last;
    int           n_checks = 0;
    int           n_fail   = 0;

    always #5 clk = ~clk;

    alu_cmd_sequencer_if #(.W(W)) bus ();

    alu_cmd_sequencer #(.W(W), .DEPTH(4), .AW(2)) dut (
        .clk          (clk),
        .clear_n      (clear_n),
        .cmd_if       (bus),
        .alu_clear    (alu_clear),
        .alu_opcode   (alu_opcode),
        .alu_input1   (alu_input1),
        .alu_input2   (alu_input2),
        .alu_out      (alu_out),
        .alu_has_last (alu_has_last)
    );

    // ALU model: first op after clear combines input1/input2, later ops
    // combine last_res with input1; NOOP outputs and keeps last_res.
    logic [W-1:0] last_res;
    logic         has_last;

    function automatic logic [W-1:0] alu_fn(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        case (op)
            OP_ADD:  return x + y;
            OP_SUB:  return x - y;
            OP_MULT: return W'(x * y);
            OP_DIV:  return (y == '0) ? '0 : x / y;
            OP_AND:  return x & y;
            OP_OR:   return x | y;
            OP_XOR:  return x ^ y;
            OP_NOT:  return ~x;
            default: return '0;
        endcase
    endfunction

    always_comb begin
        if (alu_opcode == OP_NOOP) alu_out = last_res;
        else if (has_last)         alu_out = alu_fn(alu_opcode, last_res, alu_input1);
        else                       alu_out = alu_fn(alu_opcode, alu_input1, alu_input2);
    end
    assign alu_has_last = has_last;

    always @(posedge clk) begin
        if (alu_clear) begin
            last_res <= '0;
            has_last <= 1'b0;
        end else begin
            has_last <= 1'b1;
            if (alu_opcode != OP_NOOP) last_res <= alu_out;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Offer one command until accepted (bounded); returns 1 step after acceptance.
    task automatic push(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input logic last);
        logic acc;
        bus.cmd_op = op; bus.cmd_a = a; bus.cmd_b = b; bus.cmd_last = last;
        bus.cmd_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            acc = bus.cmd_ready;
            tick();
            if (acc) break;
        end
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_res(input int max, output logic seen);
        seen = 1'b0;
        for (int i = 0; i < max; i++) begin
            if (bus.res_valid) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic ack;
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
    endtask

    task automatic test_reset;
        clear_n = 1'b0;
        repeat (2) tick();
        n_checks++; if (alu_clear !== 1'b1) begin n_fail++; $display("FAIL reset_alu_clear: got %b expected 1", alu_clear); end
        n_checks++; if (alu_opcode !== OP_NOOP) begin n_fail++; $display("FAIL reset_opcode: got %h expected 0", alu_opcode); end
        n_checks++; if (bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid: got %b expected 0", bus.res_valid); end
        n_checks++; if (bus.res_data !== 16'h0) begin n_fail++; $display("FAIL reset_res_data: got %h expected 0", bus.res_data); end
        n_checks++; if (bus.res_count !== 8'h0) begin n_fail++; $display("FAIL reset_res_count: got %h expected 0", bus.res_count); end
        n_checks++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready: got %b expected 1", bus.cmd_ready); end
        clear_n = 1'b1;
        tick();
        n_checks++; if (alu_clear !== 1'b0) begin n_fail++; $display("FAIL idle_alu_clear: got %b expected 0", alu_clear); end
    endtask

    // ADD(1,1) then ADD(a=1,last): CLEAR, ADD, NOOP, ADD -> 3, count 2.
    task automatic test_add_chain;
        push(OP_ADD, 16'd1, 16'd1, 1'b0);
        push(OP_ADD, 16'd1, 16'd0, 1'b1);
        n_checks++; if (alu_clear !== 1'b1 || alu_opcode !== OP_NOOP) begin n_fail++; $display("FAIL add_clear_cycle: got clear=%b op=%h expected clear=1 op=0", alu_clear, alu_opcode); end
        tick();
        n_checks++; if (alu_clear !== 1'b0 || alu_opcode !== OP_ADD || alu_input1 !== 16'd1 || alu_input2 !== 16'd1) begin n_fail++; $display("FAIL add_first: got clear=%b op=%h a=%h b=%h expected 0/1/1/1", alu_clear, alu_opcode, alu_input1, alu_input2); end
        n_checks++; if (bus.res_count !== 8'd0) begin n_fail++; $display("FAIL add_count_pre: got %0d expected 0", bus.res_count); end
        tick();
        n_checks++; if (alu_opcode !== OP_NOOP) begin n_fail++; $display("FAIL add_warm: got op=%h expected 0", alu_opcode); end
        tick();
        n_checks++; if (alu_opcode !== OP_ADD || alu_input1 !== 16'd1 || alu_out !== 16'd3) begin n_fail++; $display("FAIL add_issue: got op=%h a=%h out=%h expected 1/1/3", alu_opcode, alu_input1, alu_out); end
        tick();
        n_checks++; if (bus.res_valid !== 1'b1 || bus.res_data !== 16'd3 || bus.res_count !== 8'd2) begin n_fail++; $display("FAIL add_result: got v=%b d=%h c=%0d expected 1/3/2", bus.res_valid, bus.res_data, bus.res_count); end
        ack();
        n_checks++; if (bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL add_valid_drop: got %b expected 0", bus.res_valid); end
    endtask

    // Single-op chain from idle: res_valid rises on the fourth cycle.
    task automatic test_latency;
        logic [3:0] vhist;
        push(OP_ADD, 16'd2, 16'd2, 1'b1);
        vhist[0] = bus.res_valid;
        tick(); vhist[1] = bus.res_valid;
        tick(); vhist[2] = bus.res_valid;
        tick(); vhist[3] = bus.res_valid;
        n_checks++; if (vhist !== 4'b1000) begin n_fail++; $display("FAIL latency_valid: got %b expected 1000", vhist); end
        n_checks++; if (bus.res_data !== 16'd4 || bus.res_count !== 8'd1) begin n_fail++; $display("FAIL latency_result: got d=%h c=%0d expected 4/1", bus.res_data, bus.res_count); end
        ack();
    endtask

    // Two chains queued back to back: SUB -> 13, MULT -> 8.
    task automatic test_back_to_back;
        logic seen;
        push(OP_SUB, 16'd15, 16'd1, 1'b0);
        push(OP_SUB, 16'd1, 16'd0, 1'b1);
        push(OP_MULT, 16'd2, 16'd2, 1'b0);
        push(OP_MULT, 16'd2, 16'd0, 1'b1);
        wait_res(30, seen);
        n_checks++; if (seen !== 1'b1 || bus.res_data !== 16'd13 || bus.res_count !== 8'd2) begin n_fail++; $display("FAIL sub_result: got seen=%b d=%h c=%0d expected 1/13/2", seen, bus.res_data, bus.res_count); end
        ack();
        wait_res(30, seen);
        n_checks++; if (seen !== 1'b1 || bus.res_data !== 16'd8 || bus.res_count !== 8'd2) begin n_fail++; $display("FAIL mult_result: got seen=%b d=%h c=%0d expected 1/8/2", seen, bus.res_data, bus.res_count); end
        ack();
    endtask

    // Fill the FIFO while a result is held; fifth command waits for a pop.
    task automatic test_fifo_full;
        logic seen, acc;
        push(OP_ADD, 16'd1, 16'd1, 1'b1);
        wait_res(20, seen);
        n_checks++; if (seen !== 1'b1 || bus.res_data !== 16'd2) begin n_fail++; $display("FAIL full_pre_result: got seen=%b d=%h expected 1/2", seen, bus.res_data); end
        push(OP_ADD, 16'd2, 16'd3, 1'b0);
        push(OP_ADD, 16'd4, 16'd0, 1'b0);
        push(OP_ADD, 16'd5, 16'd0, 1'b0);
        push(OP_ADD, 16'd6, 16'd0, 1'b1);
        n_checks++; if (bus.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %b expected 0", bus.cmd_ready); end
        bus.cmd_op = OP_ADD; bus.cmd_a = 16'd7; bus.cmd_b = 16'd1; bus.cmd_last = 1'b1;
        bus.cmd_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (bus.cmd_ready !== 1'b0 || bus.res_valid !== 1'b1 || bus.res_data !== 16'd2) begin n_fail++; $display("FAIL full_stall%0d: got rdy=%b v=%b d=%h expected 0/1/2", i, bus.cmd_ready, bus.res_valid, bus.res_data); end
        end
        ack();
        acc = 1'b0;
        for (int i = 0; i < 10; i++) begin
            acc = bus.cmd_ready;
            tick();
            if (acc) break;
        end
        bus.cmd_valid = 1'b0;
        n_checks++; if (acc !== 1'b1) begin n_fail++; $display("FAIL full_fifth_accept: got %b expected 1", acc); end
        wait_res(30, seen);
        n_checks++; if (seen !== 1'b1 || bus.res_data !== 16'd20 || bus.res_count !== 8'd4) begin n_fail++; $display("FAIL full_chain_a: got seen=%b d=%h c=%0d expected 1/0014/4", seen, bus.res_data, bus.res_count); end
        ack();
        wait_res(30, seen);
        n_checks++; if (seen !== 1'b1 || bus.res_data !== 16'd8 || bus.res_count !== 8'd1) begin n_fail++; $display("FAIL full_chain_b: got seen=%b d=%h c=%0d expected 1/8/1", seen, bus.res_data, bus.res_count); end
        ack();
    endtask

    // Result held while res_ready is low; ALU sees NOOP; next chain follows.
    task automatic test_hold_stall;
        logic seen;
        push(OP_AND, 16'h00F0, 16'h0FF0, 1'b0);
        push(OP_OR,  16'h0F00, 16'h0000, 1'b1);
        push(OP_XOR, 16'hFFFF, 16'h00FF, 1'b1);
        wait_res(30, seen);
        n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL hold_seen: got %b expected 1", seen); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (bus.res_valid !== 1'b1 || bus.res_data !== 16'h0FF0 || alu_opcode !== OP_NOOP || alu_input1 !== 16'h0) begin n_fail++; $display("FAIL hold_stable%0d: got v=%b d=%h op=%h a=%h expected 1/0ff0/0/0", i, bus.res_valid, bus.res_data, alu_opcode, alu_input1); end
        end
        ack();
        n_checks++; if (bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL hold_drop: got %b expected 0", bus.res_valid); end
        wait_res(30, seen);
        n_checks++; if (seen !== 1'b1 || bus.res_data !== 16'hFF00 || bus.res_count !== 8'd1) begin n_fail++; $display("FAIL hold_next: got seen=%b d=%h c=%0d expected 1/ff00/1", seen, bus.res_data, bus.res_count); end
        ack();
    endtask

    // 257 ops in one chain: count saturates at 255.
    task automatic test_count_saturation;
        logic seen;
        push(OP_ADD, 16'd0, 16'd0, 1'b0);
        for (int i = 0; i < 256; i++) push(OP_ADD, 16'd1, 16'd0, (i == 255));
        wait_res(40, seen);
        n_checks++; if (seen !== 1'b1 || bus.res_data !== 16'd256 || bus.res_count !== 8'd255) begin n_fail++; $display("FAIL sat_result: got seen=%b d=%h c=%0d expected 1/0100/255", seen, bus.res_data, bus.res_count); end
        ack();
    endtask

    // Reset while ISSUE has a pending last command: everything discarded.
    task automatic test_reset_mid_chain;
        push(OP_ADD, 16'd3, 16'd4, 1'b0);
        push(OP_ADD, 16'd5, 16'd0, 1'b0);
        repeat (6) tick();
        n_checks++; if (alu_opcode !== OP_NOOP || alu_clear !== 1'b0) begin n_fail++; $display("FAIL mid_stall: got op=%h clr=%b expected 0/0", alu_opcode, alu_clear); end
        bus.cmd_op = OP_ADD; bus.cmd_a = 16'd9; bus.cmd_b = 16'd0; bus.cmd_last = 1'b1;
        bus.cmd_valid = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
        n_checks++; if (alu_opcode !== OP_ADD || alu_out !== 16'd21) begin n_fail++; $display("FAIL mid_issue: got op=%h out=%h expected 1/0015", alu_opcode, alu_out); end
        clear_n = 1'b0;
        #1;
        n_checks++; if (alu_clear !== 1'b1) begin n_fail++; $display("FAIL mid_alu_clear: got %b expected 1", alu_clear); end
        tick();
        clear_n = 1'b1;
        #1;
        n_checks++; if (bus.res_valid !== 1'b0 || bus.res_data !== 16'h0 || bus.res_count !== 8'h0 || bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL mid_after: got v=%b d=%h c=%0d rdy=%b expected 0/0/0/1", bus.res_valid, bus.res_data, bus.res_count, bus.cmd_ready); end
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++; if (alu_clear !== 1'b0 || bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL mid_idle%0d: got clr=%b v=%b expected 0/0", i, alu_clear, bus.res_valid); end
        end
    endtask

    // DIV by zero: squashed with res_err when enabled, forwarded otherwise.
    task automatic test_div_zero;
        logic seen;
        push(OP_DIV, 16'd8, 16'd0, 1'b1);
        tick();
        tick();
`ifdef ALU_SEQ_ERR_EN
        n_checks++; if (alu_opcode !== OP_NOOP) begin n_fail++; $display("FAIL div0_op: got %h expected 0", alu_opcode); end
`else
        n_checks++; if (alu_opcode !== OP_DIV || alu_input1 !== 16'd8 || alu_input2 !== 16'd0) begin n_fail++; $display("FAIL div0_op: got op=%h a=%h b=%h expected 4/8/0", alu_opcode, alu_input1, alu_input2); end
`endif
        wait_res(20, seen);
        n_checks++; if (seen !== 1'b1 || bus.res_data !== 16'h0 || bus.res_count !== 8'd1) begin n_fail++; $display("FAIL div0_result: got seen=%b d=%h c=%0d expected 1/0/1", seen, bus.res_data, bus.res_count); end
`ifdef ALU_SEQ_ERR_EN
        n_checks++; if (bus.res_err !== 1'b1) begin n_fail++; $display("FAIL div0_err: got %b expected 1", bus.res_err); end
`endif
        ack();
        push(OP_DIV, 16'd8, 16'd2, 1'b1);
        wait_res(20, seen);
        n_checks++; if (seen !== 1'b1 || bus.res_data !== 16'd4) begin n_fail++; $display("FAIL div_result: got seen=%b d=%h expected 1/4", seen, bus.res_data); end
`ifdef ALU_SEQ_ERR_EN
        n_checks++; if (bus.res_err !== 1'b0) begin n_fail++; $display("FAIL div_err: got %b expected 0", bus.res_err); end
`endif
        ack();
    endtask

    initial begin
        clear_n       = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = OP_NOOP;
        bus.cmd_a     = '0;
        bus.cmd_b     = '0;
        bus.cmd_last  = 1'b0;
        bus.res_ready = 1'b0;
        test_reset();
        test_add_chain();
        test_latency();
        test_back_to_back();
        test_fifo_full();
        test_hold_stall();
        test_count_saturation();
        test_reset_mid_chain();
        test_div_zero();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
